// File: rtl/frame_sched_pkg.sv
// Shared types and default widths for the frame transmit scheduler.
package frame_sched_pkg;

  localparam int unsigned PIX_W_DEFAULT  = 12;
  localparam int unsigned ADDR_W_DEFAULT = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

endpackage

// File: rtl/frame_tx_scheduler_rr_pick.sv
// Round-robin priority selector: first asserted request after last_idx, with wrap.
module rr_pick #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_idx,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  int unsigned cand;

  // Scan last_idx+1 .. last_idx+N (mod N) and keep the first hit.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(last_idx) + i) % N;
      if (!valid && req[IDX_W'(cand)]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/frame_tx_scheduler.sv
// Per-frame round-robin sharing of the UART image sender between pixel sources,
// with an enforced inter-frame gap and a SEND watchdog.
module frame_tx_scheduler
  import frame_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned PIX_W          = PIX_W_DEFAULT,
  parameter int unsigned ADDR_W         = ADDR_W_DEFAULT,
  parameter int unsigned GAP_CYCLES     = 50_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sched_en,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*PIX_W-1:0]   pix_in,
  input  logic [ADDR_W-1:0]          addr_in,
  input  logic                       tx_done,
  output logic                       tx_en,
  output logic [PIX_W-1:0]           pix_out,
  output logic [ADDR_W-1:0]          addr_out,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         frame_done,
  output logic                       timeout_err,
  output logic [1:0]                 state_out
);

  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES);

  sched_state_t       state;
  logic [IDX_W-1:0]   last_idx;
  logic [CNT_W-1:0]   wdog;
  logic [CNT_W-1:0]   gap_cnt;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [PIX_W-1:0]   pix_arr [NUM_REQ];

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .last_idx (last_idx),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  // Unpack the per-source pixel lanes.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_pix
    assign pix_arr[k] = pix_in[k*PIX_W +: PIX_W];
  end

  // last_idx holds the granted source for the whole frame; zero when nothing granted.
  assign pix_out   = (|grant) ? pix_arr[last_idx] : '0;
  assign addr_out  = addr_in;
  assign state_out = 2'(state);

  // Frame scheduler: IDLE -> SEND (until tx_done or watchdog) -> GAP -> IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tx_en       <= 1'b0;
      grant       <= '0;
      frame_done  <= '0;
      timeout_err <= 1'b0;
      wdog        <= '0;
      gap_cnt     <= '0;
      last_idx    <= IDX_W'(NUM_REQ - 1);
    end else begin
      frame_done  <= '0;
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sched_en && pick_valid) begin
            state    <= SEND;
            grant    <= NUM_REQ'(1) << pick_idx;
            last_idx <= pick_idx;
            tx_en    <= 1'b1;
            wdog     <= '0;
          end
        end
        SEND: begin
          // tx_done takes precedence over a coincident watchdog expiry.
          if (tx_done || (wdog == WDOG_LAST)) begin
            frame_done  <= tx_done ? grant : '0;
            timeout_err <= ~tx_done;
            tx_en       <= 1'b0;
            grant       <= '0;
            gap_cnt     <= GAP_LOAD;
            state       <= GAP;
          end else begin
            wdog <= wdog + CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_tx_scheduler.sv
// Scoreboard bench for frame_tx_scheduler: stimulus predicts grant/exit events
// from round-robin and timing rules, a negedge monitor pops and compares.
module tb_frame_tx_scheduler;

  localparam int N  = 2;
  localparam int PW = 12;
  localparam int AW = 17;
  localparam int G  = 4;
  localparam int T  = 100;

  localparam int EV_GRANT = 0;
  localparam int EV_TXEN  = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_TOUT  = 3;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sched_en = 1'b0;
  logic          tx_done = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*PW-1:0] pix_in = '0;
  logic [AW-1:0] addr_in = '0;
  logic          tx_en;
  logic [PW-1:0] pix_out;
  logic [AW-1:0] addr_out;
  logic [N-1:0]  grant;
  logic [N-1:0]  frame_done;
  logic          timeout_err;
  logic [1:0]    state_out;

  int   cyc = 0;
  int   pass_cnt = 0;
  int   total = 0;
  exp_t sbq[$];

  // Reference-model state.
  int last_w = N - 1;
  int ready_edge = 0;
  int prev_x = -1;

  frame_tx_scheduler #(
    .NUM_REQ        (N),
    .PIX_W          (PW),
    .ADDR_W         (AW),
    .GAP_CYCLES     (G),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sched_en    (sched_en),
    .req         (req),
    .pix_in      (pix_in),
    .addr_in     (addr_in),
    .tx_done     (tx_done),
    .tx_en       (tx_en),
    .pix_out     (pix_out),
    .addr_out    (addr_out),
    .grant       (grant),
    .frame_done  (frame_done),
    .timeout_err (timeout_err),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int kind);
    case (kind)
      EV_GRANT: return "grant";
      EV_TXEN:  return "tx_en_len";
      EV_DONE:  return "frame_done";
      default:  return "timeout_err";
    endcase
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
  endfunction

  function automatic void push(input int kind, input int val, input int c);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = c;
    sbq.push_back(e);
  endfunction

  // Lowest requester above the last winner, else lowest requester overall.
  function automatic int rr_model(input int last, input int mask);
    for (int i = last + 1; i < N; i++) if (((mask >> i) & 1) == 1) return i;
    for (int i = 0; i <= last; i++) if (((mask >> i) & 1) == 1) return i;
    return 0;
  endfunction

  // Outside a frame the block is in GAP until two edges before ready_edge.
  function automatic int exp_state();
    return (prev_x >= 0 && cyc <= ready_edge - 2) ? 2 : 0;
  endfunction

  task automatic ev(input int kind, input int val);
    exp_t e;
    total++;
    if (sbq.size() == 0) begin
      $display("FAIL unexpected_event: got %s=%0d at cycle %0d, required none", kname(kind), val, cyc);
      return;
    end
    e = sbq.pop_front();
    if (e.kind == kind && e.val == val && e.cyc == cyc) pass_cnt++;
    else $display("FAIL event_%s: got %s=%0d at cycle %0d, required %s=%0d at cycle %0d",
                  kname(e.kind), kname(kind), val, cyc, kname(e.kind), e.val, e.cyc);
  endtask

  // Monitor: every grant change, tx_en run length, done and abort pulses.
  logic [N-1:0] prev_grant = '0;
  logic         prev_txen = 1'b0;
  int           run = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_grant = grant;
      prev_txen  = 1'b0;
      run        = 0;
    end else begin
      if (grant != prev_grant) ev(EV_GRANT, int'(grant));
      if (tx_en) run++;
      else if (prev_txen) begin
        ev(EV_TXEN, run);
        run = 0;
      end
      if (frame_done != '0) ev(EV_DONE, int'(frame_done));
      if (timeout_err) ev(EV_TOUT, 1);
      prev_grant = grant;
      prev_txen  = tx_en;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input int n, input int r, input logic en);
    req = N'(r);
    sched_en = en;
    repeat (n) begin
      chk("idle_gap_state", int'(state_out), exp_state());
      step();
    end
  endtask

  // One frame: k = SEND cycle carrying tx_done (-1 = never); mode 1 drops req and
  // sched_en mid-frame, mode 2 scrambles them.
  task automatic do_frame(input int m, input int k, input int mode);
    int w, g, x, stop;
    bit done;
    logic [PW-1:0] ep;
    req = N'(m);
    sched_en = 1'b1;
    w = rr_model(last_w, m);
    g = (cyc + 1 > ready_edge) ? cyc + 1 : ready_edge;
    done = (k >= 0 && k <= T - 1);
    x = done ? g + 1 + k : g + T;
    stop = (k >= 0 && g + k + 1 > x) ? g + k + 1 : x;
    push(EV_GRANT, 1 << w, g);
    push(EV_GRANT, 0, x);
    push(EV_TXEN, x - g, x);
    if (done) push(EV_DONE, 1 << w, x);
    else push(EV_TOUT, 1, x);
    last_w = w;
    while (cyc < g) begin
      chk("idle_gap_state", int'(state_out), exp_state());
      step();
    end
    while (cyc <= stop) begin
      tx_done = (k >= 0 && cyc == g + k);
      pix_in  = (N*PW)'($urandom);
      addr_in = AW'($urandom);
      if (cyc == g + 2 && mode == 1) begin
        req = '0;
        sched_en = 1'b0;
      end else if (cyc == g + 2 && mode == 2) begin
        req = N'($urandom);
        sched_en = 1'($urandom);
      end
      #1;
      if (cyc == g) begin
        ep = PW'(pix_in >> (w * PW));
        chk("pix_out_granted", int'(pix_out), int'(ep));
        chk("addr_out", int'(addr_out), int'(addr_in));
        chk("tx_en_send", int'(tx_en), 1);
        chk("state_send", int'(state_out), 1);
      end
      if (cyc == x) begin
        chk("state_gap", int'(state_out), 2);
        chk("pix_out_idle", int'(pix_out), 0);
        chk("addr_out_gap", int'(addr_out), int'(addr_in));
      end
      step();
    end
    tx_done = 1'b0;
    prev_x = x;
    ready_edge = x + G + 2;
  endtask

  // Asynchronous reset on SEND cycle 10; outputs must clear before any clock edge.
  task automatic rst_mid();
    int w, g;
    req = N'(3);
    sched_en = 1'b1;
    w = rr_model(last_w, 3);
    g = (cyc + 1 > ready_edge) ? cyc + 1 : ready_edge;
    push(EV_GRANT, 1 << w, g);
    while (cyc < g + 10) step();
    chk("tx_en_before_rst", int'(tx_en), 1);
    rst = 1'b1;
    #1;
    chk("rst_async_tx_en", int'(tx_en), 0);
    chk("rst_async_grant", int'(grant), 0);
    chk("rst_async_state", int'(state_out), 0);
    step();
    step();
    rst = 1'b0;
    last_w = N - 1;
    ready_edge = cyc + 1;
    prev_x = -1;
  endtask

  initial begin
    step();
    step();
    step();
    chk("reset_tx_en", int'(tx_en), 0);
    chk("reset_grant", int'(grant), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_timeout_err", int'(timeout_err), 0);
    chk("reset_state", int'(state_out), 0);
    chk("reset_pix_out", int'(pix_out), 0);
    rst = 1'b0;
    ready_edge = cyc + 1;

    // Single source, then both held: grants alternate, none inside GAP.
    do_frame(1, 19, 0);
    for (int i = 0; i < 4; i++) do_frame(3, 19, 0);
    // Mid-frame req drop and sched_en low; no new grant while disabled.
    do_frame(1, 19, 1);
    hold(30, 3, 1'b0);
    // Watchdog abort, tx_done on the abort cycle, tx_done landing in GAP.
    do_frame(1, -1, 0);
    do_frame(1, T - 1, 0);
    do_frame(2, T, 0);
    do_frame(3, 0, 0);
    // Asynchronous reset mid-frame; requester 0 wins afterwards.
    rst_mid();
    do_frame(3, 19, 0);

    for (int f = 0; f < 30; f++) begin
      int m, k, r, mode, pd;
      m = int'($urandom_range(1, 3));
      r = int'($urandom_range(0, 9));
      if (r < 6) k = int'($urandom_range(0, 30));
      else if (r == 6) k = -1;
      else if (r == 7) k = T - 1;
      else if (r == 8) k = T;
      else k = T - 2;
      mode = int'($urandom_range(0, 2));
      pd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0;
      if (pd > 0) hold(pd, 0, 1'b1);
      do_frame(m, k, mode);
      if (mode == 1) hold(10, 3, 1'b0);
    end

    hold(10, 0, 1'b0);
    for (int i = 0; i < 200 && sbq.size() != 0; i++) step();
    while (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      total++;
      $display("FAIL missing_%s: got no event, required %0d at cycle %0d", kname(e.kind), e.val, e.cyc);
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
